load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator side of the byte-wide data-memory port; sits between the MEM pipeline stage and the data memory.
- Accepts one load/store request at a time from the pipeline.
- Sequences one or two byte accesses: byte, or little-endian halfword.
- Returns a one-cycle response with extended load data; holds the pipeline off through req_ready while busy.

Parameters:
- ADDRESS_LINE, 8, width of the byte address; address space is 2^ADDRESS_LINE bytes.

Ports:
- clock  input  1  single system clock, all state on rising edge
- reset  input  1  synchronous, active-high
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request (high only in IDLE)
- req_write  input  1  1=store, 0=load
- req_size  input  1  0=byte, 1=halfword
- req_signed  input  1  byte load: 1=sign-extend, 0=zero-extend; ignored otherwise
- req_addr  input  ADDRESS_LINE  byte address
- req_wdata  input  16  store data; byte store uses [7:0]
- rsp_valid  output  1  one-cycle completion pulse (loads and stores)
- rsp_rdata  output  16  load result, valid with rsp_valid; 0 for stores
- rsp_error  output  1  misaligned access flag, valid with rsp_valid
- mem_address  output  ADDRESS_LINE  data-memory address
- mem_write_data  output  8  data-memory write byte
- mem_write  output  1  data-memory write enable (memory writes on clock edge)
- mem_read  output  1  data-memory read enable
- mem_read_data  input  8  data-memory read byte; combinational, same cycle as mem_read

Behaviour:
- Interface: one clock, clock; reset is synchronous and active-high.
- States: IDLE, ACC0, ACC1, RESP.
- Reset values: state=IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_error=0; mem_write=0; mem_read=0; mem_address=0; mem_write_data=0.
- Reset while busy: abandons the operation and produces no response. While reset is high, mem_write and mem_read are forced 0 combinationally.
- IDLE: on req_valid && req_ready, capture write/size/signed/addr/wdata and go to ACC0. req_ready = (state==IDLE); there is no acceptance in any other state.
- ACC0: mem_address = addr; mem_read = !write; mem_write = write; mem_write_data = wdata[7:0].
  - Load: register mem_read_data into lo at the clock edge.
  - Next state: ACC1 if size=1, else RESP.
- ACC1: mem_address = addr+1, truncated to ADDRESS_LINE bits (address 2^ADDRESS_LINE-1 wraps to 0); mem_write_data = wdata[15:8]; hi captured for loads; next state RESP.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE.
  - Byte load: rsp_rdata = {8{lo[7]} if signed else 8'h00, lo}.
  - Halfword load: rsp_rdata = {hi, lo}.
  - Store: rsp_rdata = 0.
- In IDLE and RESP, all mem_* strobes are 0. mem_address and mem_write_data hold their last values; this is don't-care.
- Latency from the accept edge to rsp_valid: byte = 2 cycles, halfword = 3 cycles.
- Back-to-back throughput: a new request is accepted the cycle after RESP.
- rsp_rdata and rsp_error are held stable after rsp_valid until the next RESP.
- Never drive mem_read and mem_write in the same cycle.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: a halfword request with req_addr[0]=1 goes IDLE -> RESP directly with no memory strobes; rsp_error=1, rsp_rdata=0.
- Undefined: rsp_error is tied to 0; misaligned halfwords execute as two byte accesses, with the ACC1 address wrap as above.

Test Plan:
- Reset, then load byte at addr 0x01 with data memory reset image (0x01=0x05, 0x02=0x06), unsigned -> rsp_valid 2 cycles after accept, rsp_rdata=0x0005, exactly one mem_read pulse at address 0x01.
- Store halfword 0xA1B2 to 0x10, then load halfword from 0x10 -> memory[0x10]=0xB2, memory[0x11]=0xA1; load returns 0xA1B2 with 3-cycle latency; req_ready low for 3 cycles per request.
- Store byte 0x80 to 0x20, then load byte from 0x20 signed -> 0xFF80; unsigned -> 0x0080.
- Halfword store 0x1234 to 0xFF (ADDRESS_LINE=8) -> without macro: memory[0xFF]=0x34, memory[0x00]=0x12, rsp_error=0; with LSU_MISALIGN_TRAP_EN: no mem_write pulse, rsp_error=1 in RESP.
- Assert reset during ACC0 of a halfword store -> no ACC1 write occurs, no rsp_valid; req_ready=1 the cycle after reset deasserts.
- req_valid held high continuously with 4 byte loads -> accepts exactly every 3 cycles, 4 rsp_valid pulses, mem_read and mem_write never high together.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the byte-wide data-memory port.
// Sequences a byte access or a little-endian halfword (two byte accesses)
// and returns a one-cycle response carrying extended load data.
// Optional build macro: LSU_MISALIGN_TRAP_EN (trap odd-address halfwords).
module load_store_unit #(
  parameter int unsigned ADDRESS_LINE = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic                    req_size,
  input  logic                    req_signed,
  input  logic [ADDRESS_LINE-1:0] req_addr,
  input  logic [15:0]             req_wdata,
  output logic                    rsp_valid,
  output logic [15:0]             rsp_rdata,
  output logic                    rsp_error,
  output logic [ADDRESS_LINE-1:0] mem_address,
  output logic [7:0]              mem_write_data,
  output logic                    mem_write,
  output logic                    mem_read,
  input  logic [7:0]              mem_read_data
);

  localparam int unsigned AW = ADDRESS_LINE;

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t          state;
  state_t          state_next;
  logic            op_write;
  logic            op_size;
  logic            op_signed;
  logic [AW-1:0]   op_addr;
  logic [7:0]      op_wdata_hi;
  logic [7:0]      lo;
  logic            misaligned_c;
  logic            in_access_c;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned_c = req_size & req_addr[0];
`else
  assign misaligned_c = 1'b0;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (req_valid) state_next = misaligned_c ? RESP : ACC0;
      ACC0: state_next = op_size ? ACC1 : RESP;
      ACC1: state_next = RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake and memory strobes decoded from state; strobes squashed under reset
  assign in_access_c = (state == ACC0) || (state == ACC1);
  assign req_ready   = (state == IDLE);
  assign rsp_valid   = (state == RESP);
  assign mem_read    = in_access_c & ~op_write & ~reset;
  assign mem_write   = in_access_c &  op_write & ~reset;

  // Request capture, memory address/data sequencing and response data
  always_ff @(posedge clock) begin
    if (reset) begin
      op_write       <= 1'b0;
      op_size        <= 1'b0;
      op_signed      <= 1'b0;
      op_addr        <= '0;
      op_wdata_hi    <= 8'h00;
      lo             <= 8'h00;
      mem_address    <= '0;
      mem_write_data <= 8'h00;
      rsp_rdata      <= 16'h0000;
      rsp_error      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_write       <= req_write;
            op_size        <= req_size;
            op_signed      <= req_signed;
            op_addr        <= req_addr;
            op_wdata_hi    <= req_wdata[15:8];
            mem_address    <= req_addr;
            mem_write_data <= req_wdata[7:0];
            if (misaligned_c) begin
              rsp_rdata <= 16'h0000;
              rsp_error <= 1'b1;
            end
          end
        end
        ACC0: begin
          if (!op_write) lo <= mem_read_data;
          if (op_size) begin
            // Second byte address wraps at the top of the address space
            mem_address    <= AW'(op_addr + AW'(1));
            mem_write_data <= op_wdata_hi;
          end else begin
            rsp_rdata <= op_write ? 16'h0000
                                  : {{8{op_signed & mem_read_data[7]}}, mem_read_data};
            rsp_error <= 1'b0;
          end
        end
        ACC1: begin
          rsp_rdata <= op_write ? 16'h0000 : {mem_read_data, lo};
          rsp_error <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed bench for load_store_unit with a byte memory model.
module tb_load_store_unit;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_size;
  logic        req_signed;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_error;
  logic [7:0]  mem_address;
  logic [7:0]  mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [7:0]  mem_read_data;

  logic [7:0]  mem [0:255];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          reads = 0;
  int          writes = 0;
  int          rsps = 0;
  int          both = 0;
  int          acc_n = 0;
  int          acc_cyc [0:31];
  logic [7:0]  last_raddr = 8'h00;

  load_store_unit #(.ADDRESS_LINE(8)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_write(mem_write),
    .mem_read(mem_read), .mem_read_data(mem_read_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign mem_read_data = mem[mem_address];

  always @(posedge clock) begin
    if (mem_write) mem[mem_address] <= mem_write_data;
  end

  always @(posedge clock) begin
    cyc = cyc + 1;
    if (mem_read && mem_write) both = both + 1;
    if (mem_read) begin
      reads = reads + 1;
      last_raddr = mem_address;
    end
    if (mem_write) writes = writes + 1;
    if (rsp_valid) rsps = rsps + 1;
    if (req_valid && req_ready && !reset) begin
      acc_cyc[acc_n % 32] = cyc;
      acc_n = acc_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request from an IDLE negedge and wait (bounded) for its response.
  task automatic do_req(input logic w, input logic sz, input logic sg, input logic [7:0] a,
                        input logic [15:0] wd, output logic [15:0] rd, output logic er,
                        output int lat, output int ready_low);
    @(negedge clock);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(negedge clock);
    req_valid = 1'b0;
    lat = 99; ready_low = 0; rd = 16'hxxxx; er = 1'bx;
    for (int n = 1; n <= 10; n++) begin
      if (!req_ready) ready_low++;
      if (rsp_valid) begin
        lat = n; rd = rsp_rdata; er = rsp_error;
        break;
      end
      @(negedge clock);
    end
  endtask

  logic [15:0] rd;
  logic        er;
  int          lat, rlow, r0, w0, s0, a0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h01] = 8'h05;
    mem[8'h02] = 8'h06;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 1'b0;
    req_signed = 1'b0; req_addr = 8'h00; req_wdata = 16'h0000;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Reset values
    check("rst_req_ready", 32'(req_ready), 32'h1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'h0);
    check("rst_rsp_error", 32'(rsp_error), 32'h0);
    check("rst_mem_read", 32'(mem_read), 32'h0);
    check("rst_mem_write", 32'(mem_write), 32'h0);
    check("rst_mem_address", 32'(mem_address), 32'h0);
    check("rst_mem_wdata", 32'(mem_write_data), 32'h0);

    // Unsigned byte load from reset image
    r0 = reads;
    do_req(1'b0, 1'b0, 1'b0, 8'h01, 16'h0000, rd, er, lat, rlow);
    check("lb_data", 32'(rd), 32'h0005);
    check("lb_latency", 32'(lat), 32'd2);
    check("lb_read_pulses", 32'(reads - r0), 32'd1);
    check("lb_read_addr", 32'(last_raddr), 32'h01);

    // Halfword store then load back
    do_req(1'b1, 1'b1, 1'b0, 8'h10, 16'hA1B2, rd, er, lat, rlow);
    check("sh_latency", 32'(lat), 32'd3);
    check("sh_rdata", 32'(rd), 32'h0);
    check("sh_ready_low", 32'(rlow), 32'd3);
    check("sh_mem10", 32'(mem[8'h10]), 32'hB2);
    check("sh_mem11", 32'(mem[8'h11]), 32'hA1);
    do_req(1'b0, 1'b1, 1'b0, 8'h10, 16'h0000, rd, er, lat, rlow);
    check("lh_data", 32'(rd), 32'hA1B2);
    check("lh_latency", 32'(lat), 32'd3);
    check("lh_ready_low", 32'(rlow), 32'd3);

    // Byte store 0x80 then signed / unsigned byte loads
    do_req(1'b1, 1'b0, 1'b0, 8'h20, 16'h0080, rd, er, lat, rlow);
    check("sb_latency", 32'(lat), 32'd2);
    check("sb_mem20", 32'(mem[8'h20]), 32'h80);
    do_req(1'b0, 1'b0, 1'b1, 8'h20, 16'h0000, rd, er, lat, rlow);
    check("lb_signed", 32'(rd), 32'hFF80);
    do_req(1'b0, 1'b0, 1'b0, 8'h20, 16'h0000, rd, er, lat, rlow);
    check("lb_unsigned", 32'(rd), 32'h0080);

    // Misaligned halfword store at the top of the address space
    w0 = writes;
    do_req(1'b1, 1'b1, 1'b0, 8'hFF, 16'h1234, rd, er, lat, rlow);
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis_error", 32'(er), 32'h1);
    check("mis_rdata", 32'(rd), 32'h0);
    check("mis_latency", 32'(lat), 32'd1);
    check("mis_no_write", 32'(writes - w0), 32'd0);
    check("mis_memFF", 32'(mem[8'hFF]), 32'h00);
`else
    check("wrap_error", 32'(er), 32'h0);
    check("wrap_latency", 32'(lat), 32'd3);
    check("wrap_writes", 32'(writes - w0), 32'd2);
    check("wrap_memFF", 32'(mem[8'hFF]), 32'h34);
    check("wrap_mem00", 32'(mem[8'h00]), 32'h12);
`endif

    // Reset asserted during ACC0 of a halfword store
    @(negedge clock);
    check("abort_ready_before", 32'(req_ready), 32'h1);
    req_valid = 1'b1; req_write = 1'b1; req_size = 1'b1; req_signed = 1'b0;
    req_addr = 8'h30; req_wdata = 16'h5566;
    w0 = writes; s0 = rsps;
    @(negedge clock);
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("abort_mem_write_forced", 32'(mem_write), 32'h0);
    check("abort_mem_read_forced", 32'(mem_read), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    check("abort_ready_after", 32'(req_ready), 32'h1);
    repeat (4) @(negedge clock);
    check("abort_no_writes", 32'(writes - w0), 32'd0);
    check("abort_no_rsp", 32'(rsps - s0), 32'd0);
    check("abort_mem30", 32'(mem[8'h30]), 32'h00);
    check("abort_mem31", 32'(mem[8'h31]), 32'h00);

    // req_valid held high across four byte loads
    a0 = acc_n; s0 = rsps;
    req_valid = 1'b1; req_write = 1'b0; req_size = 1'b0; req_signed = 1'b0;
    req_addr = 8'h02; req_wdata = 16'h0000;
    for (int i = 0; i < 40 && acc_n < a0 + 4; i++) @(negedge clock);
    req_valid = 1'b0;
    for (int i = 0; i < 20 && rsps < s0 + 4; i++) @(negedge clock);
    check("b2b_accepts", 32'(acc_n - a0), 32'd4);
    check("b2b_rsps", 32'(rsps - s0), 32'd4);
    for (int k = 1; k < 4; k++)
      check($sformatf("b2b_gap%0d", k),
            32'(acc_cyc[(a0 + k) % 32] - acc_cyc[(a0 + k - 1) % 32]), 32'd3);
    check("b2b_rdata", 32'(rsp_rdata), 32'h0006);
    check("never_rd_and_wr", 32'(both), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
